// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM stage, mem_wb_reg and the WB stage.
// Buses are declared [N-1:0]; the leftmost (MSB) bit is big-endian bit 0.
package mem_access_stage_pkg;

    // DSize encodings (2'b11 is handled as a word)
    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

    localparam int TIMEOUT_DEF = 16;

    // MEM/WB bundle: LSB position of each field, nextPC in the top bits
    localparam int MEMWB_W     = 179;
    localparam int MW_MUL      = 0;
    localparam int MW_FPREGWR  = 1;
    localparam int MW_FBUSW    = 2;    // 64 bits
    localparam int MW_FDEST    = 66;   // 5 bits
    localparam int MW_TRAP     = 71;
    localparam int MW_DSIZE    = 72;   // 2 bits
    localparam int MW_LOADSIGN = 74;
    localparam int MW_MEMTOREG = 75;
    localparam int MW_REGWRITE = 76;
    localparam int MW_PCTOREG  = 77;
    localparam int MW_DATA     = 78;   // 32 bits
    localparam int MW_ALU      = 110;  // 32 bits
    localparam int MW_DEST     = 142;  // 5 bits
    localparam int MW_NEXTPC   = 147;  // 32 bits

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_access_stage_dmem_align.sv
// Byte-enable, store-data replication and misalignment detection.
// dmem_be is written MSB-first: the leftmost bit enables big-endian byte 0.
module dmem_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  dsize,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);

    // Decode access size against the low address bits
    always_comb begin
        be       = 4'b1111;
        wdata    = store_data;
        misalign = 1'b0;
        case (dsize)
            DS_BYTE: begin
                be    = 4'b1000 >> offset;
                wdata = {4{store_data[7:0]}};
            end
            DS_HALF: begin
                be       = offset[1] ? 4'b0011 : 4'b1100;
                wdata    = {2{store_data[15:0]}};
                misalign = offset[0];
            end
            default: begin
                misalign = |offset;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: data-memory req/ack handshake, stall/timeout control and
// assembly of the MEM/WB bundle. Load data leaves raw; WB extends it.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int OUT_W   = MEMWB_W,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [31:0]      nextPC,
    input  logic [31:0]      aluResult,
    input  logic [31:0]      storeData,
    input  logic [4:0]       destReg,
    input  logic [4:0]       fDestReg,
    input  logic [63:0]      fbusW,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             PCtoReg,
    input  logic             RegWrite,
    input  logic             MemToReg,
    input  logic             loadSign,
    input  logic             FPRegWrite,
    input  logic             mul,
    input  logic             trap_in,
    input  logic [1:0]       DSize,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [31:0]      dmem_wdata,
    input  logic [31:0]      dmem_rdata,
    input  logic             dmem_ack,
    output logic             stall,
    output logic             mem_fault,
    output logic [OUT_W-1:0] out
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    mem_state_e  state;
    logic [7:0]  cnt;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic        we_q, flush_seen;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_mis;

    dmem_align u_align (
        .dsize      (DSize),
        .offset     (aluResult[1:0]),
        .store_data (storeData),
        .be         (al_be),
        .wdata      (al_wdata),
        .misalign   (al_mis)
    );

    logic live, access, in_idle, in_wait, issue, mis_fault;
    logic wait_ack, time_out, flushed, bubble, load_done;
    logic [31:0] addr_now;

    assign addr_now  = {aluResult[31:2], 2'b00};
    assign live      = in_valid & ~flush;
    assign access    = live & (MemRead | MemWrite) & ~trap_in;
    assign in_idle   = reset & (state == ST_IDLE);
    assign in_wait   = reset & (state == ST_WAIT);
    assign issue     = in_idle & access & ~al_mis;
    assign mis_fault = in_idle & access & al_mis;
    assign wait_ack  = in_wait & dmem_ack;
    // ack wins over a timeout landing in the same cycle
    assign time_out  = in_wait & ~dmem_ack & (cnt == CNT_LAST);
    // a flush seen at any point of the wait turns completion into a bubble
    assign flushed   = in_wait & (flush_seen | flush);
    assign load_done = MemRead & ((issue & dmem_ack) | wait_ack);

    assign dmem_req   = issue | (in_wait & ~time_out);
    assign dmem_we    = dmem_req & (in_wait ? we_q : MemWrite);
    assign dmem_addr  = in_wait ? addr_q  : addr_now;
    assign dmem_be    = in_wait ? be_q    : al_be;
    assign dmem_wdata = in_wait ? wdata_q : al_wdata;

    assign stall     = (issue & ~dmem_ack) | (in_wait & ~dmem_ack & ~time_out);
    assign mem_fault = mis_fault | (time_out & ~flushed);
    assign bubble    = ~live | stall | flushed;

    // MEM/WB bundle; control bits cleared for bubbles and faults
    always_comb begin
        logic [MEMWB_W-1:0] bundle;
        logic [31:0]        data_out;
        data_out = (load_done & ~bubble) ? dmem_rdata : 32'd0;
        bundle = {nextPC, destReg, aluResult, data_out,
                  PCtoReg & ~bubble,
                  RegWrite & ~bubble & ~mis_fault & ~time_out,
                  MemToReg & ~bubble & ~time_out,
                  loadSign, DSize,
                  ~bubble & (trap_in | mis_fault | time_out),
                  fDestReg, fbusW,
                  FPRegWrite & ~bubble & ~mis_fault,
                  mul};
        out = reset ? OUT_W'(bundle) : '0;
    end

    // FSM: capture the request on entry to WAIT, count until ack or timeout.
    // The counter starts at 1 so the issue cycle counts toward TIMEOUT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            we_q       <= 1'b0;
            flush_seen <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue && !dmem_ack) begin
                        state      <= ST_WAIT;
                        cnt        <= 8'd1;
                        addr_q     <= addr_now;
                        wdata_q    <= al_wdata;
                        be_q       <= al_be;
                        we_q       <= MemWrite;
                        flush_seen <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (wait_ack || time_out) begin
                        state      <= ST_IDLE;
                        cnt        <= 8'd0;
                        flush_seen <= 1'b0;
                    end else begin
                        cnt        <= cnt + 8'd1;
                        flush_seen <= flush_seen | flush;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: inputs change on the falling edge,
// outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    logic         clk = 1'b0;
    logic         reset, in_valid, flush;
    logic [31:0]  nextPC, aluResult, storeData;
    logic [4:0]   destReg, fDestReg;
    logic [63:0]  fbusW;
    logic         MemRead, MemWrite, PCtoReg, RegWrite, MemToReg;
    logic         loadSign, FPRegWrite, mul, trap_in;
    logic [1:0]   DSize;
    logic         dmem_req, dmem_we, dmem_ack, stall, mem_fault;
    logic [31:0]  dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]   dmem_be;
    logic [178:0] out;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.OUT_W(179), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .flush(flush),
        .nextPC(nextPC), .aluResult(aluResult), .storeData(storeData),
        .destReg(destReg), .fDestReg(fDestReg), .fbusW(fbusW),
        .MemRead(MemRead), .MemWrite(MemWrite), .PCtoReg(PCtoReg),
        .RegWrite(RegWrite), .MemToReg(MemToReg), .loadSign(loadSign),
        .FPRegWrite(FPRegWrite), .mul(mul), .trap_in(trap_in), .DSize(DSize),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack), .stall(stall), .mem_fault(mem_fault), .out(out)
    );

    task automatic clear_in();
        in_valid = 0; flush = 0; nextPC = 32'h0000_1004; aluResult = 0;
        storeData = 0; destReg = 0; fDestReg = 0; fbusW = 0;
        MemRead = 0; MemWrite = 0; PCtoReg = 0; RegWrite = 0; MemToReg = 0;
        loadSign = 0; FPRegWrite = 0; mul = 0; trap_in = 0; DSize = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [1:0] ds);
        clear_in();
        in_valid = 1; aluResult = a; DSize = ds; MemRead = 1;
        RegWrite = 1; MemToReg = 1; destReg = 5'd5;
    endtask

    task automatic set_store(input logic [31:0] a, input logic [1:0] ds,
                             input logic [31:0] d);
        clear_in();
        in_valid = 1; aluResult = a; DSize = ds; MemWrite = 1; storeData = d;
    endtask

    task automatic test_reset();
        set_load(32'h100, DS_WORD);
        reset = 0;
        @(negedge clk); @(negedge clk); #1;
        checks++; if (dmem_req !== 1'b0) $display("FAIL rst_req got %b want 0", dmem_req); else passed++;
        checks++; if (dmem_we !== 1'b0) $display("FAIL rst_we got %b want 0", dmem_we); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL rst_stall got %b want 0", stall); else passed++;
        checks++; if (mem_fault !== 1'b0) $display("FAIL rst_fault got %b want 0", mem_fault); else passed++;
        checks++; if (out !== '0) $display("FAIL rst_out got %h want 0", out); else passed++;
        @(negedge clk); reset = 1; clear_in();
    endtask

    task automatic test_word_load();
        int n;
        @(negedge clk); set_load(32'h100, DS_WORD); #1;
        checks++; if (dmem_req !== 1'b1) $display("FAIL wl_req got %b want 1", dmem_req); else passed++;
        checks++; if (dmem_we !== 1'b0) $display("FAIL wl_we got %b want 0", dmem_we); else passed++;
        checks++; if (dmem_addr !== 32'h100) $display("FAIL wl_addr got %h want 100", dmem_addr); else passed++;
        checks++; if (dmem_be !== 4'b1111) $display("FAIL wl_be got %b want 1111", dmem_be); else passed++;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            if (stall === 1'b1 && out[MW_REGWRITE] === 1'b0 && out[MW_MEMTOREG] === 1'b0
                && dmem_req === 1'b1) n++;
            @(negedge clk); #1;
        end
        checks++; if (n !== 3) $display("FAIL wl_stall_bubbles got %0d want 3", n); else passed++;
        @(negedge clk); dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; #1;
        // that last negedge advanced one more cycle, so re-run: see below
        checks++; if (stall !== 1'b0) $display("FAIL wl_done_stall got %b want 0", stall); else passed++;
        checks++; if (out[MW_DATA +: 32] !== 32'hDEADBEEF) $display("FAIL wl_data got %h want deadbeef", out[MW_DATA +: 32]); else passed++;
        checks++; if (out[MW_REGWRITE] !== 1'b1) $display("FAIL wl_regwrite got %b want 1", out[MW_REGWRITE]); else passed++;
        checks++; if (out[MW_DEST +: 5] !== 5'd5) $display("FAIL wl_dest got %0d want 5", out[MW_DEST +: 5]); else passed++;
        @(negedge clk); clear_in(); #1;
        checks++; if (dmem_req !== 1'b0) $display("FAIL wl_idle_req got %b want 0", dmem_req); else passed++;
    endtask

    task automatic test_byte_store();
        @(negedge clk); set_store(32'h203, DS_BYTE, 32'h0000_00A5); dmem_ack = 1; #1;
        checks++; if (dmem_be !== 4'b0001) $display("FAIL bs_be got %b want 0001", dmem_be); else passed++;
        checks++; if (dmem_wdata !== 32'hA5A5A5A5) $display("FAIL bs_wdata got %h want a5a5a5a5", dmem_wdata); else passed++;
        checks++; if (dmem_we !== 1'b1) $display("FAIL bs_we got %b want 1", dmem_we); else passed++;
        checks++; if (dmem_addr !== 32'h200) $display("FAIL bs_addr got %h want 200", dmem_addr); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL bs_stall got %b want 0", stall); else passed++;
        @(negedge clk); clear_in(); #1;
        checks++; if (stall !== 1'b0 || dmem_req !== 1'b0) $display("FAIL bs_after got stall=%b req=%b want 0 0", stall, dmem_req); else passed++;
        // half store at offset 2: low half lanes, data replicated twice
        @(negedge clk); set_store(32'h402, DS_HALF, 32'hFFFF_1234); dmem_ack = 1; #1;
        checks++; if (dmem_be !== 4'b0011) $display("FAIL hs_be got %b want 0011", dmem_be); else passed++;
        checks++; if (dmem_wdata !== 32'h12341234) $display("FAIL hs_wdata got %h want 12341234", dmem_wdata); else passed++;
        // half at offset 0 and DSize=11 handled as word
        @(negedge clk); set_store(32'h400, DS_HALF, 32'h0); dmem_ack = 1; #1;
        checks++; if (dmem_be !== 4'b1100) $display("FAIL hs0_be got %b want 1100", dmem_be); else passed++;
        @(negedge clk); set_store(32'h404, 2'b11, 32'hCAFE0001); dmem_ack = 1; #1;
        checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'hCAFE0001) $display("FAIL ds11 got be=%b wd=%h want 1111 cafe0001", dmem_be, dmem_wdata); else passed++;
        @(negedge clk); clear_in();
    endtask

    task automatic test_misaligned();
        @(negedge clk); set_load(32'h101, DS_HALF); #1;
        checks++; if (dmem_req !== 1'b0) $display("FAIL mis_req got %b want 0", dmem_req); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL mis_stall got %b want 0", stall); else passed++;
        checks++; if (mem_fault !== 1'b1) $display("FAIL mis_fault got %b want 1", mem_fault); else passed++;
        checks++; if (out[MW_TRAP] !== 1'b1) $display("FAIL mis_trap got %b want 1", out[MW_TRAP]); else passed++;
        checks++; if (out[MW_REGWRITE] !== 1'b0) $display("FAIL mis_regwrite got %b want 0", out[MW_REGWRITE]); else passed++;
        @(negedge clk); set_load(32'h102, DS_WORD); #1;
        checks++; if (mem_fault !== 1'b1 || dmem_req !== 1'b0) $display("FAIL misw got fault=%b req=%b want 1 0", mem_fault, dmem_req); else passed++;
        @(negedge clk); clear_in(); #1;
        checks++; if (mem_fault !== 1'b0) $display("FAIL mis_pulse got %b want 0", mem_fault); else passed++;
    endtask

    task automatic test_timeout();
        int n;
        @(negedge clk); set_load(32'h300, DS_WORD); #1;
        n = 0;
        while (stall === 1'b1 && n < 40) begin
            n++;
            @(negedge clk); #1;
        end
        checks++; if (n !== 15) $display("FAIL to_stall_cycles got %0d want 15", n); else passed++;
        checks++; if (dmem_req !== 1'b0) $display("FAIL to_req got %b want 0", dmem_req); else passed++;
        checks++; if (mem_fault !== 1'b1) $display("FAIL to_fault got %b want 1", mem_fault); else passed++;
        checks++; if (out[MW_TRAP] !== 1'b1) $display("FAIL to_trap got %b want 1", out[MW_TRAP]); else passed++;
        checks++; if (out[MW_REGWRITE] !== 1'b0 || out[MW_MEMTOREG] !== 1'b0) $display("FAIL to_ctl got rw=%b m2r=%b want 0 0", out[MW_REGWRITE], out[MW_MEMTOREG]); else passed++;
        // next instruction: plain ALU op passes straight through
        @(negedge clk); clear_in(); in_valid = 1; RegWrite = 1; aluResult = 32'h0BAD_F00D; mul = 1; #1;
        checks++; if (stall !== 1'b0 || mem_fault !== 1'b0) $display("FAIL alu_ctl got stall=%b fault=%b want 0 0", stall, mem_fault); else passed++;
        checks++; if (out[MW_REGWRITE] !== 1'b1 || out[MW_ALU +: 32] !== 32'h0BAD_F00D) $display("FAIL alu_pass got rw=%b alu=%h want 1 0badf00d", out[MW_REGWRITE], out[MW_ALU +: 32]); else passed++;
        checks++; if (out[MW_DATA +: 32] !== 32'd0 || out[MW_MUL] !== 1'b1) $display("FAIL alu_data got d=%h mul=%b want 0 1", out[MW_DATA +: 32], out[MW_MUL]); else passed++;
        in_valid = 0; #1;
        checks++; if (out[MW_REGWRITE] !== 1'b0) $display("FAIL invalid_bubble got %b want 0", out[MW_REGWRITE]); else passed++;
        // trap_in: no access, trap forwarded
        @(negedge clk); set_load(32'h100, DS_WORD); trap_in = 1; #1;
        checks++; if (dmem_req !== 1'b0 || out[MW_TRAP] !== 1'b1) $display("FAIL trapin got req=%b trap=%b want 0 1", dmem_req, out[MW_TRAP]); else passed++;
        @(negedge clk); clear_in();
    endtask

    task automatic test_flush_wait();
        int held;
        @(negedge clk); set_load(32'h400, DS_WORD); #1;
        held = 0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            flush = (k == 2);
            dmem_ack = (k == 4);
            dmem_rdata = 32'h5555_AAAA;
            #1;
            if (dmem_req === 1'b1 && dmem_addr === 32'h400) held++;
            if (k == 2) begin
                checks++; if (out[MW_REGWRITE] !== 1'b0) $display("FAIL fl_mid_bubble got %b want 0", out[MW_REGWRITE]); else passed++;
            end
        end
        checks++; if (held !== 4) $display("FAIL fl_req_held got %0d want 4", held); else passed++;
        checks++; if (stall !== 1'b0) $display("FAIL fl_stall got %b want 0", stall); else passed++;
        checks++; if (out[MW_REGWRITE] !== 1'b0 || out[MW_MEMTOREG] !== 1'b0 || out[MW_TRAP] !== 1'b0) $display("FAIL fl_bubble got rw=%b m2r=%b trap=%b want 0 0 0", out[MW_REGWRITE], out[MW_MEMTOREG], out[MW_TRAP]); else passed++;
        checks++; if (mem_fault !== 1'b0) $display("FAIL fl_fault got %b want 0", mem_fault); else passed++;
        @(negedge clk); clear_in();
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk); set_load(32'h500, DS_WORD); #1;
        @(negedge clk); #1;
        checks++; if (stall !== 1'b1) $display("FAIL rw_wait_stall got %b want 1", stall); else passed++;
        @(negedge clk); reset = 0; #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0 || out !== '0) $display("FAIL rw_reset got req=%b stall=%b want 0 0", dmem_req, stall); else passed++;
        @(negedge clk); reset = 1; clear_in(); #1;
        checks++; if (dmem_req !== 1'b0 || stall !== 1'b0) $display("FAIL rw_idle got req=%b stall=%b want 0 0", dmem_req, stall); else passed++;
        @(negedge clk); set_load(32'h504, DS_WORD); dmem_ack = 1; dmem_rdata = 32'h1234_5678; #1;
        checks++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h504 || stall !== 1'b0) $display("FAIL rw_load got req=%b addr=%h stall=%b want 1 504 0", dmem_req, dmem_addr, stall); else passed++;
        checks++; if (out[MW_DATA +: 32] !== 32'h1234_5678) $display("FAIL rw_data got %h want 12345678", out[MW_DATA +: 32]); else passed++;
        @(negedge clk); clear_in();
    endtask

    task automatic test_back_to_back();
        @(negedge clk); set_load(32'h600, DS_WORD); #1;
        @(negedge clk); dmem_ack = 1; dmem_rdata = 32'h0000_0042; #1;
        checks++; if (out[MW_DATA +: 32] !== 32'h42 || stall !== 1'b0) $display("FAIL b2b_first got d=%h stall=%b want 42 0", out[MW_DATA +: 32], stall); else passed++;
        @(negedge clk); set_store(32'h608, DS_WORD, 32'h7777_0000); #1;
        checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h608) $display("FAIL b2b_second got req=%b we=%b addr=%h want 1 1 608", dmem_req, dmem_we, dmem_addr); else passed++;
        @(negedge clk); dmem_ack = 1; #1;
        checks++; if (stall !== 1'b0 || dmem_wdata !== 32'h7777_0000) $display("FAIL b2b_done got stall=%b wd=%h want 0 77770000", stall, dmem_wdata); else passed++;
        @(negedge clk); clear_in();
    endtask

    initial begin
        clear_in();
        reset = 0;
        test_reset();
        test_word_load();
        test_byte_store();
        test_misaligned();
        test_timeout();
        test_flush_wait();
        test_reset_in_wait();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
